// File: rtl/pbit_clamp_sequencer_pkg.sv
// Shared types, sizes and helper functions for the p-bit clamp sequencer.
// The default sizes here are the ones the sequencer is built with.
package pbit_clamp_pkg;

    localparam int NUM_PBITS  = 53;
    localparam int H_W        = 8;
    localparam int MAG_W      = H_W - 1;
    localparam int CLAMP_N    = 8;
    localparam int CLAMP_BASE = NUM_PBITS - 16;
    localparam int CNT_W      = 16;
    localparam int RAMP_STEP  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } clamp_state_t;

    // The sum is formed one bit wider than the magnitude, so it never wraps
    // before being compared with the target.
    function automatic logic [MAG_W-1:0] sat_add_mag(
        input logic [MAG_W-1:0] mag,
        input logic [MAG_W-1:0] step,
        input logic [MAG_W-1:0] target
    );
        logic [H_W-1:0] sum;
        sum = {1'b0, mag} + {1'b0, step};
        if (sum > {1'b0, target}) begin
            return target;
        end
        return sum[MAG_W-1:0];
    endfunction

    // The magnitude is at most 2^(H_W-1)-1, so the negative value is never the
    // asymmetric most-negative code.
    function automatic logic signed [H_W-1:0] force_val(
        input logic             b,
        input logic [MAG_W-1:0] mag
    );
        logic signed [H_W-1:0] p;
        p = $signed({1'b0, mag});
        return b ? p : -p;
    endfunction

endpackage

// File: rtl/pbit_clamp_sequencer_if.sv
// Clamp request channel. A request transfers on a cycle where req_valid and
// req_ready are both high; the payload is sampled only in that cycle.
interface pbit_clamp_sequencer_if #(
    parameter int CLAMP_N = 8,
    parameter int H_W     = 8,
    parameter int CNT_W   = 16
);
    logic               req_valid;
    logic               req_ready;
    logic [CLAMP_N-1:0] req_pattern;
    logic [CLAMP_N-1:0] req_mask;
    logic [H_W-2:0]     req_strength;
    logic [CNT_W-1:0]   req_hold;

    modport master (
        output req_valid, req_pattern, req_mask, req_strength, req_hold,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_pattern, req_mask, req_strength, req_hold,
        output req_ready
    );
endinterface

// File: rtl/pbit_clamp_sequencer_ramp_ctrl.sv
// Clamp sequencing FSM: ramps the forced magnitude to the target, holds it
// for hold+1 cycles, then returns to IDLE with a done or aborted pulse.
module pbit_clamp_sequencer_ramp_ctrl
    import pbit_clamp_pkg::*;
#(
    parameter int CNT_W     = pbit_clamp_pkg::CNT_W,
    parameter int RAMP_STEP = pbit_clamp_pkg::RAMP_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept_i,
    input  logic             abort_i,
    input  logic [MAG_W-1:0] target_i,
    input  logic [CNT_W-1:0] hold_i,
    output clamp_state_t     state_o,
    output logic             busy_o,
    output logic [MAG_W-1:0] mag_o,
    output logic             done_o,
    output logic             aborted_o
);

    localparam logic [MAG_W-1:0] STEP = MAG_W'(RAMP_STEP);

    clamp_state_t     state_q, state_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_i) begin
                    state_d = RAMP;
                    mag_d   = '0;
                end
            end
            RAMP: begin
                if (abort_i) begin
                    state_d   = IDLE;
                    mag_d     = '0;
                    aborted_d = 1'b1;
                end else if (mag_q == target_i) begin
                    state_d = HOLD;
                    cnt_d   = hold_i;
                end else begin
                    mag_d = sat_add_mag(mag_q, STEP, target_i);
                end
            end
            HOLD: begin
                // Abort takes priority over a completion in the same cycle.
                if (abort_i) begin
                    state_d   = IDLE;
                    mag_d     = '0;
                    aborted_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    mag_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                mag_d   = '0;
            end
        endcase
    end

    always_comb begin
        state_o   = state_q;
        busy_o    = (state_q != IDLE);
        mag_o     = mag_q;
        done_o    = done_q;
        aborted_o = aborted_q;
    end

endmodule

// File: rtl/pbit_clamp_sequencer.sv
// Registered, ramped clamp between the bias stage and the p-bit array: holds
// the request latches and the output bias register array.
module pbit_clamp_sequencer
    import pbit_clamp_pkg::*;
#(
    parameter int NUM_PBITS  = pbit_clamp_pkg::NUM_PBITS,
    parameter int CLAMP_N    = pbit_clamp_pkg::CLAMP_N,
    parameter int CLAMP_BASE = NUM_PBITS - 16,
    parameter int CNT_W      = pbit_clamp_pkg::CNT_W,
    parameter int RAMP_STEP  = pbit_clamp_pkg::RAMP_STEP
) (
    input  logic                  clk,
    input  logic                  rst,
    pbit_clamp_sequencer_if.slave req_if,
    input  logic signed [H_W-1:0] h_i [NUM_PBITS],
    input  logic                  abort_i,
    output logic signed [H_W-1:0] h_clamped_o [NUM_PBITS],
    output logic                  clamp_active_o,
    output logic [MAG_W-1:0]      cur_mag_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output clamp_state_t          dbg_state_o
);

    logic               accept;
    logic               busy;
    logic [MAG_W-1:0]   mag;
    logic [CLAMP_N-1:0] pattern_q, mask_q;
    logic [MAG_W-1:0]   target_q;
    logic [CNT_W-1:0]   hold_q;

    logic signed [H_W-1:0] h_q [NUM_PBITS];
    logic signed [H_W-1:0] h_d [NUM_PBITS];
    logic                  active_q;
    logic [MAG_W-1:0]      cur_mag_q;

    assign req_if.req_ready = (dbg_state_o == IDLE) && !abort_i;
    assign accept           = req_if.req_valid && req_if.req_ready;

    pbit_clamp_sequencer_ramp_ctrl #(
        .CNT_W     (CNT_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .accept_i  (accept),
        .abort_i   (abort_i),
        .target_i  (target_q),
        .hold_i    (hold_q),
        .state_o   (dbg_state_o),
        .busy_o    (busy),
        .mag_o     (mag),
        .done_o    (done_o),
        .aborted_o (aborted_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= '0;
            mask_q    <= '0;
            target_q  <= '0;
            hold_q    <= '0;
        end else if (accept) begin
            pattern_q <= req_if.req_pattern;
            mask_q    <= req_if.req_mask;
            target_q  <= req_if.req_strength;
            hold_q    <= req_if.req_hold;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PBITS; i++) begin
            h_d[i] = h_i[i];
        end
        for (int j = 0; j < CLAMP_N; j++) begin
            if (busy && mask_q[j]) begin
                h_d[CLAMP_BASE + j] = force_val(pattern_q[j], mag);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PBITS; i++) begin
                h_q[i] <= '0;
            end
            active_q  <= 1'b0;
            cur_mag_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PBITS; i++) begin
                h_q[i] <= h_d[i];
            end
            active_q  <= busy;
            cur_mag_q <= busy ? mag : '0;
        end
    end

    assign h_clamped_o    = h_q;
    assign clamp_active_o = active_q;
    assign cur_mag_o      = cur_mag_q;

endmodule

// File: tb/tb_pbit_clamp_sequencer.sv
// Directed bench for pbit_clamp_sequencer: per-cycle vector table plus
// hand-written reset sequences.
module tb_pbit_clamp_sequencer;
    import pbit_clamp_pkg::*;

    logic clk;
    logic rst;
    logic abort;
    logic signed [7:0] h [53];
    logic signed [7:0] h_clamped [53];
    logic        clamp_active;
    logic [6:0]  cur_mag;
    logic        done;
    logic        aborted;
    clamp_state_t dbg_state;

    pbit_clamp_sequencer_if #(.CLAMP_N(8), .H_W(8), .CNT_W(16)) bus ();

    pbit_clamp_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .req_if         (bus),
        .h_i            (h),
        .abort_i        (abort),
        .h_clamped_o    (h_clamped),
        .clamp_active_o (clamp_active),
        .cur_mag_o      (cur_mag),
        .done_o         (done),
        .aborted_o      (aborted),
        .dbg_state_o    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_miss;

    typedef struct {
        logic       valid;
        logic       abort;
        logic [7:0] pat;
        logic [7:0] mask;
        logic [6:0] str;
        logic [15:0] hold;
        logic       e_ready;
        logic       e_act;
        int         e_mag;
        logic       e_done;
        logic       e_abrt;
        int         e_h37;
        int         e_h38;
        int         e_h41;
    } vec_t;

    vec_t vecs[$];
    logic [7:0]  cur_pat;
    logic [7:0]  cur_mask;
    logic [6:0]  cur_str;
    logic [15:0] cur_hold;

    function automatic void add(input logic v, input logic a, input logic rdy,
                                input logic act, input int mag, input logic dn,
                                input logic ab, input int h37, input int h38,
                                input int h41);
        vec_t t;
        t.valid = v; t.abort = a;
        t.pat = cur_pat; t.mask = cur_mask; t.str = cur_str; t.hold = cur_hold;
        t.e_ready = rdy; t.e_act = act; t.e_mag = mag; t.e_done = dn;
        t.e_abrt = ab; t.e_h37 = h37; t.e_h38 = h38; t.e_h41 = h41;
        vecs.push_back(t);
    endfunction

    // scoreboard compare
    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s [vec %0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic a);
        bus.req_valid    = v;
        abort            = a;
        bus.req_pattern  = cur_pat;
        bus.req_mask     = cur_mask;
        bus.req_strength = cur_str;
        bus.req_hold     = cur_hold;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int P37 = 17;
    localparam int P38 = 18;
    localparam int P41 = 21;

    initial begin
        int bad;
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 53; i++) h[i] = 8'(i - 20);
        cur_pat = 8'b10110001; cur_mask = 8'hFF; cur_str = 7'd0; cur_hold = 16'd0;
        drive(1'b0, 1'b0);
        rst = 1'b1;

        // reset state
        step();
        step();
        chk("rst_h0", -1, int'(h_clamped[0]), 0);
        chk("rst_h37", -1, int'(h_clamped[37]), 0);
        chk("rst_act", -1, int'(clamp_active), 0);
        chk("rst_mag", -1, int'(cur_mag), 0);
        chk("rst_done", -1, int'(done), 0);
        chk("rst_abrt", -1, int'(aborted), 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", -1, int'(bus.req_ready), 1);
        step();
        bad = 0;
        for (int i = 0; i < 53; i++) if (int'(h_clamped[i]) != i - 20) bad++;
        chk("pass_all_bad_idx", -1, bad, 0);
        chk("pass_act", -1, int'(clamp_active), 0);

        // full mask, strength 50, hold 3
        cur_pat = 8'b10110001; cur_mask = 8'hFF; cur_str = 7'd50; cur_hold = 16'd3;
        add(1, 0, 1, 0, 0, 0, 0, P37, P38, P41);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 16, 0, 0, 16, -16, 16);
        add(0, 0, 0, 1, 32, 0, 0, 32, -32, 32);
        add(0, 0, 0, 1, 48, 0, 0, 48, -48, 48);
        add(0, 0, 0, 1, 50, 0, 0, 50, -50, 50);
        add(0, 0, 0, 1, 50, 0, 0, 50, -50, 50);
        add(0, 0, 0, 1, 50, 0, 0, 50, -50, 50);
        add(0, 0, 0, 1, 50, 0, 0, 50, -50, 50);
        add(0, 0, 0, 1, 50, 1, 0, 50, -50, 50);
        add(0, 0, 1, 0, 0, 0, 0, P37, P38, P41);

        // partial mask: 41 passes through
        cur_mask = 8'b00001111; cur_str = 7'd20; cur_hold = 16'd0;
        add(1, 0, 1, 0, 0, 0, 0, P37, P38, P41);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, P41);
        add(0, 0, 0, 1, 16, 0, 0, 16, -16, P41);
        add(0, 0, 0, 1, 20, 0, 0, 20, -20, P41);
        add(0, 0, 0, 1, 20, 1, 0, 20, -20, P41);
        add(0, 0, 1, 0, 0, 0, 0, P37, P38, P41);

        // saturation at 127, single HOLD cycle
        cur_mask = 8'hFF; cur_str = 7'd127; cur_hold = 16'd0;
        add(1, 0, 1, 0, 0, 0, 0, P37, P38, P41);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) add(0, 0, 0, 1, 16 * k, 0, 0, 16 * k, -16 * k, 16 * k);
        add(0, 0, 0, 1, 127, 0, 0, 127, -127, 127);
        add(0, 0, 0, 1, 127, 1, 0, 127, -127, 127);
        add(0, 0, 1, 0, 0, 0, 0, P37, P38, P41);

        // abort in HOLD, blocked accept, abort in RAMP
        cur_str = 7'd16; cur_hold = 16'd5;
        add(1, 0, 1, 0, 0, 0, 0, P37, P38, P41);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 16, 0, 0, 16, -16, 16);
        add(0, 0, 0, 1, 16, 0, 0, 16, -16, 16);
        add(0, 1, 0, 1, 16, 0, 1, 16, -16, 16);
        add(1, 1, 0, 0, 0, 0, 0, P37, P38, P41);
        add(1, 0, 1, 0, 0, 0, 0, P37, P38, P41);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 16, 0, 1, 16, -16, 16);
        add(0, 0, 1, 0, 0, 0, 0, P37, P38, P41);

        foreach (vecs[n]) begin
            cur_pat = vecs[n].pat; cur_mask = vecs[n].mask;
            cur_str = vecs[n].str; cur_hold = vecs[n].hold;
            drive(vecs[n].valid, vecs[n].abort);
            #1;
            chk("req_ready", n, int'(bus.req_ready), int'(vecs[n].e_ready));
            step();
            chk("clamp_active", n, int'(clamp_active), int'(vecs[n].e_act));
            chk("cur_mag", n, int'(cur_mag), vecs[n].e_mag);
            chk("done", n, int'(done), int'(vecs[n].e_done));
            chk("aborted", n, int'(aborted), int'(vecs[n].e_abrt));
            chk("h37", n, int'(h_clamped[37]), vecs[n].e_h37);
            chk("h38", n, int'(h_clamped[38]), vecs[n].e_h38);
            chk("h41", n, int'(h_clamped[41]), vecs[n].e_h41);
        end

        // reset in the middle of RAMP, then immediate new request
        cur_pat = 8'b10110001; cur_mask = 8'hFF; cur_str = 7'd50; cur_hold = 16'd3;
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_h37", -2, int'(h_clamped[37]), 0);
        chk("mid_rst_h0", -2, int'(h_clamped[0]), 0);
        chk("mid_rst_act", -2, int'(clamp_active), 0);
        chk("mid_rst_mag", -2, int'(cur_mag), 0);
        chk("mid_rst_done", -2, int'(done), 0);
        chk("mid_rst_abrt", -2, int'(aborted), 0);
        chk("mid_rst_state", -2, int'(dbg_state), int'(IDLE));
        rst = 1'b0;
        drive(1'b1, 1'b0);
        #1;
        chk("post_rst_ready", -2, int'(bus.req_ready), 1);
        step();
        drive(1'b0, 1'b0);
        chk("post_rst_h37", -2, int'(h_clamped[37]), P37);
        chk("post_rst_act0", -2, int'(clamp_active), 0);
        step();
        chk("post_rst_act1", -2, int'(clamp_active), 1);
        chk("post_rst_mag", -2, int'(cur_mag), 0);
        step();
        chk("post_rst_mag16", -2, int'(cur_mag), 16);
        chk("post_rst_h38", -2, int'(h_clamped[38]), -16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pbit_clamp_sequencer.md
Name: pbit_clamp_sequencer

Overview:
- Parametrised successor to the static output clamper in the p-bit circuit template.
- Accepts a clamp request over a valid/ready handshake: bit pattern, per-bit mask, target strength and hold time.
- Ramps the magnitude of the forced bias of the clamped window from 0 up to the target, holds it for a programmed number of cycles, then releases and reports done.
- Sits between the bias/weight-sum stage and the p-bit array; replaces the combinational clamp with a registered, annealing-friendly clamp.

Parameters:
- NUM_PBITS, 53, total number of p-bits (h vector length).
- H_W, 8, signed bias width.
- CLAMP_N, 8, number of clampable p-bits in the window.
- CLAMP_BASE, NUM_PBITS-16, index of the first clamped p-bit; requires CLAMP_BASE+CLAMP_N <= NUM_PBITS.
- CNT_W, 16, width of the hold counter.
- RAMP_STEP, 16, magnitude increment per ramp cycle; legal range 1..2^(H_W-1)-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- h  in  signed [H_W-1:0] x NUM_PBITS  bias vector from the floating operation.
- req_valid  in  1  clamp request present.
- req_ready  out  1  block can accept a request (combinational from state and abort).
- req_pattern  in  CLAMP_N  desired value per clamped bit (1 forces +mag, 0 forces -mag).
- req_mask  in  CLAMP_N  1 = bit clamped, 0 = bit passes h through.
- req_strength  in  H_W-1 unsigned  target magnitude.
- req_hold  in  CNT_W  hold count.
- abort  in  1  terminate the active clamp.
- h_clamped  out  signed [H_W-1:0] x NUM_PBITS  registered output bias vector.
- clamp_active  out  1  h_clamped currently carries forced values.
- cur_mag  out  H_W-1  magnitude currently applied.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (sync, rst=1):
  - state=IDLE; h_clamped all 0; clamp_active=0; cur_mag=0; done=0; aborted=0.
  - Latched pattern, mask, target and hold cleared.
- States: IDLE, RAMP, HOLD.
- Handshake:
  - req_ready = (state==IDLE) && !abort.
  - Accept occurs when req_valid && req_ready. On accept, latch pattern, mask, strength and hold; set mag=0; next state = RAMP.
  - Request inputs are ignored outside the accept cycle.
- RAMP, evaluated each cycle:
  - If mag==target: next state = HOLD, cnt=hold.
  - Otherwise mag = min(mag+RAMP_STEP, target). The addition is done at H_W bits so it cannot overflow.
  - target=0 gives exactly one RAMP cycle at mag 0.
- HOLD, evaluated each cycle:
  - If cnt==0: next state = IDLE, done=1 for one cycle, mag=0.
  - Otherwise cnt = cnt-1.
  - HOLD lasts hold+1 cycles; hold=0 gives a single HOLD cycle.
- Abort:
  - In RAMP or HOLD: next state = IDLE, mag=0, aborted=1 for one cycle, no done pulse.
  - In IDLE: abort has no effect beyond blocking accept.
- Output datapath, registered with 1-cycle latency from the state/mag of cycle N to h_clamped in cycle N+1:
  - For i in CLAMP_BASE..CLAMP_BASE+CLAMP_N-1, with j = i-CLAMP_BASE: if state!=IDLE and mask[j]=1, then h_clamped[i] = pattern[j] ? +mag : -mag, sign-extended to H_W.
  - All other indices, and all indices in IDLE, take h_clamped[i] = h[i] from the previous cycle.
  - Forced values are symmetric; most negative is -(2^(H_W-1)-1), never -2^(H_W-1).
- clamp_active and cur_mag are registered alongside h_clamped, so they are cycle-aligned with it.
- done and aborted are registered and assert in the cycle the state returns to IDLE.
- Back-to-back requests: a new accept is possible in the cycle after done or aborted, since IDLE is reached then.
- rst asserted mid-RAMP or mid-HOLD: next cycle follows the reset values above, with no done or aborted pulse.

Decomposition:
- Package pbit_clamp_pkg:
  - state enum clamp_state_t {IDLE, RAMP, HOLD}.
  - Function sat_add_mag(mag, step, target).
  - Function force_val(bit, mag) returning signed H_W.
  - Shares num_Pbits from global_params.
- Sub-module clamp_ramp_ctrl: FSM, mag and cnt. The top level holds the request latches and the output register array.

Test Plan:
- Reset then IDLE, h[i]=i-20 for all i -> next cycle h_clamped[i]=i-20; clamp_active=0; req_ready=1.
- Request pattern=8'b10110001, mask=8'hFF, strength=50, hold=3, RAMP_STEP=16:
  - cur_mag sequence 0,16,32,48,50 while in RAMP, then 50 held for 4 HOLD cycles.
  - h_clamped[37]=+50 and h_clamped[38]=-50 during HOLD.
  - done pulses once; next cycle passthrough resumes.
- mask=8'b00001111 -> indices 41..44 follow h with 1-cycle lag while 37..40 are forced.
- strength=127, hold=0 -> mag saturates at 127 (no wrap). Forced values are +127 and -127. Exactly 1 HOLD cycle, then done.
- abort asserted during the 2nd HOLD cycle -> aborted pulse, no done, passthrough next cycle. A request held valid with abort=1 in IDLE is not accepted.
- rst pulsed during RAMP -> all outputs 0 the next cycle. A new request is accepted right after rst drops.
